// File: rtl/pst_pkg.sv
// Shared definitions for the predictive phase array.
//   PW_DEFAULT : default phase width
//   state_t    : sweep controller states
//   phase_step : learning step with a forced minimum of 1 for any non-zero error
package pst_pkg;

    localparam int PW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A plain right shift would stall small errors forever; forcing a step of 1
    // lets the prediction land exactly on the actual phase.
    function automatic logic [31:0] phase_step(input logic [31:0] mag, input int shift);
        logic [31:0] s;
        s = mag >> shift;
        if (s == 32'd0 && mag != 32'd0)
            s = 32'd1;
        return s;
    endfunction

endpackage

// File: rtl/phase_err_unit.sv
// Combinational per-channel datapath: prediction error and next prediction.
//   actual    : snapshotted phase of the channel
//   pred      : current prediction of the channel
//   learn     : 1 = next_pred moves toward actual, 0 = next_pred = pred
//   mag       : |actual - pred|
//   sign      : 1 when actual is later than pred
//   surprise  : mag above the surprise threshold
//   next_pred : updated prediction
module phase_err_unit
    import pst_pkg::*;
#(
    parameter int PW          = PW_DEFAULT,
    parameter int LR_SHIFT    = 2,
    parameter int SURPRISE_TH = 16
) (
    input  logic [PW-1:0] actual,
    input  logic [PW-1:0] pred,
    input  logic          learn,
    output logic [PW-1:0] mag,
    output logic          sign,
    output logic          surprise,
    output logic [PW-1:0] next_pred
);

    logic [PW:0]   diff;
    logic [PW-1:0] step;

    always_comb begin
        diff      = {1'b0, actual} - {1'b0, pred};
        // Negative difference: magnitude is pred - actual, which fits in PW bits.
        mag       = diff[PW] ? (pred - actual) : diff[PW-1:0];
        sign      = ~diff[PW] & (diff != '0);
        surprise  = (32'(mag) > 32'(SURPRISE_TH));
        // step never exceeds mag, so the update cannot overshoot or wrap.
        step      = PW'(phase_step(32'(mag), LR_SHIFT));
        next_pred = pred;
        if (learn)
            next_pred = sign ? (pred + step) : (pred - step);
    end

endmodule

// File: rtl/predictive_phase_array.sv
// N-channel time-multiplexed predictive phase unit. On cycle_start the channel
// phases and fired flags are snapshotted, then one channel is processed per
// clock; a summary total_err and sweep_done follow the last channel.
//   clk, rst_n         : clock, async active-low reset
//   cycle_start        : gamma cycle boundary, starts a sweep
//   actual_phase_flat  : channel k at [k*PW +: PW]
//   fired_flat         : channel k fired
//   learn_en           : enable prediction updates
//   err_ch/err_mag/err_sign/surprise/err_valid : per-channel result strobe
//   pred_phase_flat    : registered predictions
//   total_err          : summed error of the last completed sweep
//   sweep_done         : one-clock completion pulse
//   overrun            : sticky, cycle_start seen mid-sweep
//
// state | meaning
// IDLE  | waiting for cycle_start
// SWEEP | processing channel idx, one per clock
// DONE  | publishing total_err and pulsing sweep_done
module predictive_phase_array
    import pst_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int PW          = PW_DEFAULT,
    parameter int PRED_INIT   = 128,
    parameter int LR_SHIFT    = 2,
    parameter int SURPRISE_TH = 16,
    parameter int CHW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cycle_start,
    input  logic [N_CH*PW-1:0]   actual_phase_flat,
    input  logic [N_CH-1:0]      fired_flat,
    input  logic                 learn_en,
    output logic [CHW-1:0]       err_ch,
    output logic [PW-1:0]        err_mag,
    output logic                 err_sign,
    output logic                 err_valid,
    output logic                 surprise,
    output logic [N_CH*PW-1:0]   pred_phase_flat,
    output logic [PW+CHW-1:0]    total_err,
    output logic                 sweep_done,
    output logic                 overrun
);

    localparam int ACW = PW + CHW;

    state_t              state;
    logic [CHW-1:0]      idx;
    logic [N_CH*PW-1:0]  snap_phase;
    logic [N_CH-1:0]     snap_fired;
    logic [N_CH*PW-1:0]  pred_q;
    logic [ACW-1:0]      acc;

    logic [PW-1:0]       act_cur;
    logic [PW-1:0]       pred_cur;
    logic [PW-1:0]       u_mag;
    logic                u_sign;
    logic                u_surprise;
    logic [PW-1:0]       u_next;

    assign act_cur         = snap_phase[idx*PW +: PW];
    assign pred_cur        = pred_q[idx*PW +: PW];
    assign pred_phase_flat = pred_q;

    phase_err_unit #(
        .PW          (PW),
        .LR_SHIFT    (LR_SHIFT),
        .SURPRISE_TH (SURPRISE_TH)
    ) u_err (
        .actual    (act_cur),
        .pred      (pred_cur),
        .learn     (learn_en),
        .mag       (u_mag),
        .sign      (u_sign),
        .surprise  (u_surprise),
        .next_pred (u_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            snap_phase <= '0;
            snap_fired <= '0;
            pred_q     <= {N_CH{PW'(PRED_INIT)}};
            acc        <= '0;
            err_ch     <= '0;
            err_mag    <= '0;
            err_sign   <= 1'b0;
            err_valid  <= 1'b0;
            surprise   <= 1'b0;
            total_err  <= '0;
            sweep_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            err_valid  <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cycle_start) begin
                        snap_phase <= actual_phase_flat;
                        snap_fired <= fired_flat;
                        acc        <= '0;
                        idx        <= '0;
                        state      <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (cycle_start) begin
                        // Abort: the channel at idx is not processed this edge.
                        overrun    <= 1'b1;
                        snap_phase <= actual_phase_flat;
                        snap_fired <= fired_flat;
                        acc        <= '0;
                        idx        <= '0;
                    end else begin
                        if (snap_fired[idx]) begin
                            err_valid <= 1'b1;
                            err_ch    <= idx;
                            err_mag   <= u_mag;
                            err_sign  <= u_sign;
                            surprise  <= u_surprise;
                            acc       <= acc + ACW'(u_mag);
                            if (learn_en)
                                pred_q[idx*PW +: PW] <= u_next;
                        end
                        if (idx == CHW'(N_CH - 1))
                            state <= DONE;
                        else
                            idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    total_err  <= acc;
                    sweep_done <= 1'b1;
                    if (cycle_start) begin
                        snap_phase <= actual_phase_flat;
                        snap_fired <= fired_flat;
                        acc        <= '0;
                        idx        <= '0;
                        state      <= SWEEP;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/predictive_phase_array.md
Name: predictive_phase_array

Overview:
- N-channel, time-multiplexed successor to the single-channel predictive phase unit.
- Each gamma cycle, it snapshots every sensory-layer channel's locked phase and fired flag.
- It then sweeps the channels one per clock. For each channel it computes the signed prediction error against a per-channel learned prediction, moves that prediction toward the actual phase, and flags surprises.
- Sits between an array of phase_neuron instances and the next predictive layer; shares cycle_start with gamma_oscillator.

Parameters:
- N_CH, 4, channel count (>=1).
- PW, 8, phase width in bits.
- PRED_INIT, 128, reset value of every prediction.
- LR_SHIFT, 2, learning-rate shift: step = err_mag >> LR_SHIFT.
- SURPRISE_TH, 16, surprise is flagged when err_mag > SURPRISE_TH.
- CHW, $clog2(N_CH) with a minimum of 1, channel index width (derived).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cycle_start  in  1  gamma cycle boundary pulse; starts a sweep.
- actual_phase_flat  in  N_CH*PW  channel k occupies bits [k*PW +: PW].
- fired_flat  in  N_CH  channel k fired in the last cycle.
- learn_en  in  1  1 = update predictions; 0 = frozen, errors still reported.
- err_ch  out  CHW  channel index of the current result.
- err_mag  out  PW  |actual - pred|.
- err_sign  out  1  1 = actual later than pred ("slow"); 0 = earlier or equal ("fast").
- err_valid  out  1  one-clock strobe per fired channel.
- surprise  out  1  qualified by err_valid.
- pred_phase_flat  out  N_CH*PW  current predictions, registered.
- total_err  out  PW+CHW  sum of err_mag over fired channels of the last completed sweep.
- sweep_done  out  1  one-clock pulse when a sweep completes.
- overrun  out  1  sticky; set when cycle_start arrives mid-sweep.

Behaviour:
- Reset (asynchronous, any state):
  - all predictions = PRED_INIT;
  - err_ch, err_mag, err_sign, err_valid, surprise, total_err, sweep_done, overrun = 0;
  - FSM = IDLE; snapshot registers = 0.
- FSM states and transitions:
  - IDLE: on cycle_start at edge T0, snapshot both inputs, clear the accumulator, idx = 0, go to SWEEP.
  - SWEEP: at edge T(k+1), process channel k = idx; outputs for channel k are visible after edge T(k+1). When idx == N_CH-1, go to DONE.
  - DONE: at edge T(N_CH+1), total_err = accumulator, sweep_done = 1 for one clock, go to IDLE.
  - Total latency from cycle_start to sweep_done: N_CH+1 clocks.
- Per channel k in SWEEP:
  - If fired[k] = 0: err_valid = 0, prediction held, accumulator unchanged; err_ch/err_mag/err_sign/surprise hold their previous values.
  - If fired[k] = 1:
    - d = actual - pred, computed at PW+1 bits signed;
    - err_mag = |d| (fits in PW bits);
    - err_sign = (d > 0);
    - surprise = (err_mag > SURPRISE_TH);
    - err_valid = 1, err_ch = k;
    - accumulator += err_mag.
  - Prediction update, only when learn_en = 1 and fired[k] = 1:
    - step = err_mag >> LR_SHIFT; if step == 0 and err_mag != 0, force step = 1;
    - pred moves toward actual by step;
    - the update never overshoots and never wraps;
    - err_mag == 0 leaves pred unchanged.
  - learn_en is sampled per channel at that channel's processing edge.
- Accumulator width is PW+CHW. N_CH*(2^PW - 1) always fits, so no saturation logic is needed.
- cycle_start while in SWEEP:
  - overrun = 1 (stays set until reset);
  - sweep aborts with no sweep_done; predictions already updated are kept;
  - new snapshot taken, idx = 0, accumulator cleared, remain in SWEEP.
- cycle_start while in DONE: sweep_done still pulses, total_err still loads, and a new sweep starts on the same edge.
- Inputs may change freely after the snapshot edge; only the snapshot is used.
- Integration requirement: gamma cycle length must exceed N_CH+1 clocks.

Decomposition:
- Shared package (pst_pkg):
  - default PW;
  - fsm state enum {IDLE, SWEEP, DONE};
  - function phase_step(err_mag, shift) implementing the forced-minimum-1 rule.
- One natural sub-module, phase_err_unit: the combinational per-channel datapath. Inputs: actual, pred, learn. Outputs: mag, sign, surprise, next_pred.
- Top level holds the FSM, snapshot registers, prediction register file and accumulator.

Test Plan (N_CH=4, PW=8, LR_SHIFT=2, SURPRISE_TH=16, PRED_INIT=128):
- Reset release: all pred = 128, all outputs 0, no err_valid before the first cycle_start.
- Convergence: ch0 actual=4, fired, repeated over cycles.
  - First cycle: err_mag=124, sign=0, surprise=1, pred 128->97.
  - Pred converges monotonically to exactly 4; final steps are err 3 -> step 1.
  - err_mag reaches 0 and stays 0.
- Sweep totals: actual {4,10,128,200}, all fired, from reset.
  - err_valid seen on ch0..3 with err_mag 124, 118, 0, 72; signs 0, 0, 0, 1.
  - total_err=314; sweep_done exactly 5 clocks after cycle_start.
- Unfired and frozen channels:
  - fired=0101: only ch0 and ch2 strobe; ch1 and ch3 preds unchanged.
  - learn_en=0: errors reported, all preds unchanged.
- Change detection: ch0 converged to 4, then actual=40 -> err_mag=36, sign=1, surprise=1; err_mag decays over the following cycles.
- Overrun: cycle_start 2 clocks into a sweep -> overrun=1, no sweep_done for the aborted sweep, new sweep completes normally; reset mid-sweep clears all state immediately.
